// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin commit arbiter for the regfile write port and pr_table free port
module wb_arbiter #(
   parameter int NREQ = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [6*NREQ-1:0]    req_rn,
   input  logic [64*NREQ-1:0]   req_data,
   output logic [NREQ-1:0]      req_ready,
   input  logic                 hold,
   output logic                 w_en,
   output logic [5:0]           w_rn,
   output logic [63:0]          w_data,
   output logic                 free_en,
   output logic [5:0]           free_rn,
   output logic [31:0]          commit_count
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [5:0]    rn_arr   [NREQ];
   logic [63:0]   data_arr [NREQ];

   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW:0]   scan_sum;
   logic [PW-1:0] scan_idx;
   logic          gnt_any;
   logic [PW-1:0] gnt_idx;
   logic [5:0]    gnt_rn;
   logic [63:0]   gnt_data;
   logic          wr_d;

   logic          w_en_q;
   logic [5:0]    rn_q;
   logic [63:0]   data_q;
   logic [31:0]   cnt_q;

   // Unpack the flat requester buses into per-requester arrays
   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign rn_arr[i]   = req_rn[6*i +: 6];
      assign data_arr[i] = req_data[64*i +: 64];
   end

   // Scan from ptr upward with wrap; first valid requester wins unless held or in reset
   always_comb begin
      req_ready = '0;
      scan_sum  = '0;
      scan_idx  = '0;
      gnt_any   = 1'b0;
      gnt_idx   = '0;
      gnt_rn    = '0;
      gnt_data  = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan_sum = {1'b0, ptr_q} + (PW+1)'(k);
         if (scan_sum >= (PW+1)'(NREQ)) begin
            scan_sum = scan_sum - (PW+1)'(NREQ);
         end
         scan_idx = scan_sum[PW-1:0];
         if (!gnt_any && req_valid[scan_idx]) begin
            gnt_any  = 1'b1;
            gnt_idx  = scan_idx;
            gnt_rn   = rn_arr[scan_idx];
            gnt_data = data_arr[scan_idx];
         end
      end
      if (hold || !rst_n) begin
         gnt_any = 1'b0;
      end
      if (gnt_any) begin
         req_ready[gnt_idx] = 1'b1;
      end
   end

   // Pointer advance past the granted index; writes to register 0 are consumed but not performed
   always_comb begin
      ptr_d = ptr_q;
      if (gnt_any) begin
         ptr_d = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
      end
      wr_d = gnt_any && (gnt_rn != 6'd0);
   end

   // Single output register: write and free are issued together the cycle after the grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q  <= '0;
         w_en_q <= 1'b0;
         rn_q   <= '0;
         data_q <= '0;
         cnt_q  <= '0;
      end else begin
         ptr_q  <= ptr_d;
         w_en_q <= wr_d;
         if (wr_d) begin
            rn_q   <= gnt_rn;
            data_q <= gnt_data;
            cnt_q  <= cnt_q + 32'd1;
         end
      end
   end

   assign w_en         = w_en_q;
   assign w_rn         = rn_q;
   assign w_data       = data_q;
   assign free_en      = w_en_q;
   assign free_rn      = rn_q;
   assign commit_count = cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed bench for wb_arbiter
module tb_wb_arbiter;

   localparam int NREQ = 5;

   logic                clk;
   logic                rst_n;
   logic [NREQ-1:0]     req_valid;
   logic [6*NREQ-1:0]   req_rn;
   logic [64*NREQ-1:0]  req_data;
   logic [NREQ-1:0]     req_ready;
   logic                hold;
   logic                w_en;
   logic [5:0]          w_rn;
   logic [63:0]         w_data;
   logic                free_en;
   logic [5:0]          free_rn;
   logic [31:0]         commit_count;

   int n_vec;
   int n_err;

   wb_arbiter #(.NREQ(NREQ)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_rn       (req_rn),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .hold         (hold),
      .w_en         (w_en),
      .w_rn         (w_rn),
      .w_data       (w_data),
      .free_en      (free_en),
      .free_rn      (free_rn),
      .commit_count (commit_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [5:0] rn, input logic [63:0] d);
      req_valid[i]        = 1'b1;
      req_rn[6*i +: 6]    = rn;
      req_data[64*i +: 64] = d;
   endtask

   task automatic clr_req(input int i);
      req_valid[i] = 1'b0;
   endtask

   task automatic after_pos;
      @(posedge clk);
      #1;
   endtask

   task automatic to_neg;
      @(negedge clk);
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      hold      = 1'b0;
      req_valid = '0;
      req_rn    = '0;
      req_data  = '0;

      // reset state, with a requester valid during reset
      set_req(0, 6'd3, 64'h1);
      #2;
      chk("rst_ready", 64'(req_ready), 64'h0);
      chk("rst_w_en", 64'(w_en), 64'h0);
      chk("rst_w_rn", 64'(w_rn), 64'h0);
      chk("rst_w_data", w_data, 64'h0);
      chk("rst_free_en", 64'(free_en), 64'h0);
      chk("rst_free_rn", 64'(free_rn), 64'h0);
      chk("rst_count", 64'(commit_count), 64'h0);
      clr_req(0);
      to_neg;
      rst_n = 1'b1;
      after_pos;

      // single requester: alu2
      set_req(1, 6'd7, 64'hDEADBEEF_00000001);
      to_neg;
      chk("single_ready", 64'(req_ready), 64'h02);
      after_pos;
      clr_req(1);
      chk("single_w_en", 64'(w_en), 64'h1);
      chk("single_w_rn", 64'(w_rn), 64'h7);
      chk("single_w_data", w_data, 64'hDEADBEEF_00000001);
      chk("single_free_en", 64'(free_en), 64'h1);
      chk("single_free_rn", 64'(free_rn), 64'h7);
      chk("single_count", 64'(commit_count), 64'h1);
      to_neg;
      chk("idle_ready", 64'(req_ready), 64'h0);
      after_pos;
      chk("idle_w_en", 64'(w_en), 64'h0);
      chk("idle_free_en", 64'(free_en), 64'h0);
      chk("idle_w_rn_held", 64'(w_rn), 64'h7);
      chk("idle_w_data_held", w_data, 64'hDEADBEEF_00000001);

      // reset pulse to bring ptr back to 0, then fairness
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < NREQ; i++) set_req(i, 6'(i + 1), 64'h100 + 64'(i));
      for (int k = 0; k < 10; k++) begin
         to_neg;
         chk($sformatf("fair_ready_%0d", k), 64'(req_ready), 64'(1 << (k % 5)));
         after_pos;
         chk($sformatf("fair_w_en_%0d", k), 64'(w_en), 64'h1);
         chk($sformatf("fair_w_rn_%0d", k), 64'(w_rn), 64'((k % 5) + 1));
         chk($sformatf("fair_w_data_%0d", k), w_data, 64'h100 + 64'(k % 5));
      end
      req_valid = '0;
      chk("fair_count", 64'(commit_count), 64'd10);

      // pointer wrap: grant 3 leaves ptr at 4, then only 0 and 4 valid
      set_req(3, 6'd9, 64'h9);
      to_neg;
      chk("wrap_ready_3", 64'(req_ready), 64'h08);
      after_pos;
      clr_req(3);
      set_req(0, 6'd11, 64'hB);
      set_req(4, 6'd10, 64'hA);
      chk("wrap_w_rn_3", 64'(w_rn), 64'd9);
      to_neg;
      chk("wrap_ready_4", 64'(req_ready), 64'h10);
      after_pos;
      clr_req(4);
      chk("wrap_w_rn_4", 64'(w_rn), 64'd10);
      to_neg;
      chk("wrap_ready_0", 64'(req_ready), 64'h01);
      after_pos;
      clr_req(0);
      chk("wrap_w_rn_0", 64'(w_rn), 64'd11);
      chk("wrap_count", 64'(commit_count), 64'd13);

      // register 0 from memunit (ptr = 1)
      set_req(3, 6'd0, 64'h5555);
      to_neg;
      chk("r0_ready", 64'(req_ready), 64'h08);
      after_pos;
      clr_req(3);
      chk("r0_w_en", 64'(w_en), 64'h0);
      chk("r0_free_en", 64'(free_en), 64'h0);
      chk("r0_count", 64'(commit_count), 64'd13);
      chk("r0_w_rn_held", 64'(w_rn), 64'd11);

      // hold: grant to 4 (ptr = 4) accepted just before hold rises
      for (int i = 0; i < NREQ; i++) set_req(i, 6'(i + 20), 64'hA000 + 64'(i));
      to_neg;
      chk("pre_hold_ready", 64'(req_ready), 64'h10);
      after_pos;
      hold = 1'b1;
      chk("pre_hold_w_en", 64'(w_en), 64'h1);
      chk("pre_hold_w_rn", 64'(w_rn), 64'd24);
      chk("pre_hold_count", 64'(commit_count), 64'd14);
      for (int k = 0; k < 3; k++) begin
         to_neg;
         chk($sformatf("hold_ready_%0d", k), 64'(req_ready), 64'h0);
         after_pos;
         chk($sformatf("hold_w_en_%0d", k), 64'(w_en), 64'h0);
         chk($sformatf("hold_count_%0d", k), 64'(commit_count), 64'd14);
      end
      hold = 1'b0;
      to_neg;
      chk("post_hold_ready", 64'(req_ready), 64'h01);
      after_pos;
      req_valid = '0;
      chk("post_hold_w_rn", 64'(w_rn), 64'd20);
      chk("post_hold_w_data", w_data, 64'hA000);
      chk("post_hold_count", 64'(commit_count), 64'd15);

      // reset mid-stream (ptr = 1, grant to 2)
      set_req(2, 6'd33, 64'h3333);
      to_neg;
      chk("mid_ready", 64'(req_ready), 64'h04);
      after_pos;
      clr_req(2);
      chk("mid_w_en_pre", 64'(w_en), 64'h1);
      set_req(1, 6'd40, 64'h4040);
      set_req(3, 6'd41, 64'h4141);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_w_en", 64'(w_en), 64'h0);
      chk("mid_rst_free_en", 64'(free_en), 64'h0);
      chk("mid_rst_count", 64'(commit_count), 64'h0);
      chk("mid_rst_w_rn", 64'(w_rn), 64'h0);
      chk("mid_rst_ready", 64'(req_ready), 64'h0);
      #1;
      rst_n = 1'b1;
      to_neg;
      chk("after_rst_ready", 64'(req_ready), 64'h02);
      after_pos;
      req_valid = '0;
      chk("after_rst_w_rn", 64'(w_rn), 64'd40);
      chk("after_rst_count", 64'(commit_count), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
